// File: rtl/id_bypass_ctrl.sv
// Decode-stage operand bypass, load-use interlock and instruction hold.
// Optional interlock cycle counter enabled by defining ID_STALL_CNT_EN.
module id_bypass_ctrl #(
    parameter int DATA_W  = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic                      ex_stall,
    input  logic                      inst_valid,
    input  logic [31:0]               inst_sram_rdata,
    output logic [31:0]               inst,
    input  logic [NUM_RD-1:0]         src_used,
    input  logic [NUM_RD*5-1:0]       src_addr,
    input  logic [NUM_RD*DATA_W-1:0]  rf_rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*5-1:0]      fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    output logic                      stallreq,
    output logic [NUM_RD*DATA_W-1:0]  opnd,
    output logic                      opnd_valid,
    output logic [31:0]               stall_cnt
);

    localparam logic [0:0] PASS = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [31:0]              hold_q, hold_d;
    logic [NUM_RD*DATA_W-1:0] opnd_q, opnd_d;
    logic                     opnd_valid_q, opnd_valid_d;
    logic [NUM_RD*DATA_W-1:0] res;
    logic [NUM_RD-1:0]        port_pend;
    logic [NUM_RD-1:0]        port_stall;
    logic                     valid_now;

    // Older sources are scanned first so the youngest match overwrites them.
    always_comb begin
        res       = rf_rdata;
        port_pend = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (fwd_we[j] &&
                    fwd_waddr[j*5 +: 5] == src_addr[i*5 +: 5]) begin
                    res[i*DATA_W +: DATA_W] = fwd_wdata[j*DATA_W +: DATA_W];
                    port_pend[i]            = fwd_pend[j];
                end
            end
            if (src_addr[i*5 +: 5] == 5'd0) begin
                res[i*DATA_W +: DATA_W] = '0;
                port_pend[i]            = 1'b0;
            end
        end
    end

    always_comb begin
        port_stall = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            port_stall[i] = src_used[i] &&
                            (src_addr[i*5 +: 5] != 5'd0) &&
                            port_pend[i];
        end
    end

    assign stallreq = |port_stall;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (flush) begin
            state_d = PASS;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                PASS: begin
                    if (inst_valid && (stallreq || ex_stall)) begin
                        state_d = HOLD;
                        hold_d  = inst_sram_rdata;
                    end
                end
                HOLD: begin
                    if (!stallreq && !ex_stall) begin
                        state_d = PASS;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end

    assign inst      = (state_q == HOLD) ? hold_q : inst_sram_rdata;
    assign valid_now = (state_q == HOLD) ? 1'b1 : inst_valid;

    // flush wins over ex_stall for the valid bit only.
    always_comb begin
        opnd_d       = opnd_q;
        opnd_valid_d = opnd_valid_q;
        if (!ex_stall) begin
            opnd_d       = res;
            opnd_valid_d = valid_now && !stallreq;
        end
        if (flush) begin
            opnd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PASS;
            hold_q       <= '0;
            opnd_q       <= '0;
            opnd_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            opnd_q       <= opnd_d;
            opnd_valid_q <= opnd_valid_d;
        end
    end

    assign opnd       = opnd_q;
    assign opnd_valid = opnd_valid_q;

`ifdef ID_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stallreq && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
